divider_fx: RTL and testbench
=============================

Name: divider_fx

Overview:
- Next-generation signed fixed-point divider for the MHA datapath, e.g. softmax normalisation and score scaling.
- Computes Q = (A << FRAC_W) / B on two's-complement operands with a restoring shift-subtract loop, one quotient bit per cycle.
- Adds over the previous divider: valid/ready handshake, operand capture, fractional quotient bits, remainder output, divide-by-zero and overflow flags, and correct handling of the most-negative value.

Parameters:
- D_W, 16: operand, quotient and remainder width (two's complement); min 4.
- FRAC_W, 8: fractional bits appended to the quotient; 0 gives integer division; range 0..D_W.

Ports:
- I_CLK  in  1  clock, all logic on rising edge.
- I_RST  in  1  synchronous reset, active-high.
- I_VLD  in  1  operand valid.
- O_RDY  out  1  ready to accept operands.
- I_DIVIDEND  in  D_W  signed dividend A.
- I_DIVISOR  in  D_W  signed divisor B.
- O_VLD  out  1  result valid.
- I_RDY  in  1  downstream ready.
- O_QUOTIENT  out  D_W  signed quotient, FRAC_W fractional bits.
- O_REMAINDER  out  D_W  signed remainder; sign follows the dividend; 0 on divide-by-zero.
- O_DZ  out  1  divide-by-zero flag, valid with O_VLD.
- O_OVF  out  1  quotient overflow flag, valid with O_VLD.

Behaviour:
- Reset: state S_IDLE. O_RDY=1, O_VLD=0, O_QUOTIENT=0, O_REMAINDER=0, O_DZ=0, O_OVF=0. All internal registers cleared.
- Reset asserted in any state, including mid-S_CALC, aborts the operation; the result is discarded.
- ITER = D_W+FRAC_W. Loop counter width = $clog2(ITER+1).
- States (one-hot): S_IDLE, S_CALC, S_DONE.
- S_IDLE:
  - O_RDY=1.
  - On I_VLD&O_RDY, register sign(A), sign(B), |A| and |B| as D_W-bit unsigned. |-2^(D_W-1)| = 2^(D_W-1) exactly.
  - Build the working numerator N = |A|<<FRAC_W (ITER bits).
  - If B==0: go to S_DONE with the DZ result.
  - Otherwise go to S_CALC; counter = ITER-1, partial remainder = 0.
- S_CALC:
  - O_RDY=0.
  - Each cycle: P' = {P, N[k]}. If P' >= |B|, then P = P'-|B| and Qmag[k]=1; else P = P' and Qmag[k]=0.
  - The partial remainder is D_W+1 bits wide, so no carry is lost.
  - After the cycle with k=0, go to S_DONE.
  - Inputs are ignored in S_CALC; the caller need not hold operands.
- S_DONE:
  - O_VLD=1. Outputs are registered and held stable until I_RDY.
  - On O_VLD&I_RDY, go to S_IDLE. O_VLD is low the next cycle; no same-cycle re-accept.
- Latency: accept at cycle 0 gives O_VLD at cycle ITER+1. Divide-by-zero gives O_VLD at cycle 1.
- Throughput: one operation per ITER+2 cycles with I_RDY held high.
- Sign rules:
  - neg = sA^sB.
  - Quotient = neg ? -Qmag : Qmag.
  - Remainder = sA ? -P : P.
  - A zero magnitude yields +0, never -0.
- Overflow:
  - O_OVF=1 when Qmag > 2^(D_W-1)-1 (positive result) or Qmag > 2^(D_W-1) (negative result).
  - Result without saturation: low D_W bits of Qmag, then conditionally negated.
- Divide-by-zero:
  - O_DZ=1, O_OVF=0, O_REMAINDER=0.
  - O_QUOTIENT = sA ? -(2^(D_W-1)-1) : 2^(D_W-1)-1. A=0 returns +max.
  - Applies regardless of the optional feature.

Optional Feature:
- Macro DIVIDER_FX_SAT_EN.
- Defined: on O_OVF, O_QUOTIENT clamps to 2^(D_W-1)-1 (positive) or -2^(D_W-1) (negative).
- Undefined: wrapped value as above; O_OVF still reported.

Decomposition:
- Package divider_pkg holds:
  - state encodings S_IDLE/S_CALC/S_DONE;
  - function div_iter(D_W, FRAC_W) returning ITER;
  - function clog2-based counter width.
- One sub-module: divider_sgn_mag, combinational two's-complement to sign/magnitude and back, D_W-parametrised. Instantiated for A, B and the output negation.

Test Plan:
- D_W=16, FRAC_W=8: A=3, B=2, I_RDY=1 -> O_VLD at cycle 25 after accept; Q=0x0180, R=0, DZ=0, OVF=0.
- A=100, B=3 -> Q=0x2155, R=1. A=-7, B=2 -> Q=0xFC80, R=0. A=-100, B=3 -> Q=0xDEAB, R=0xFFFF.
- A=5, B=0 -> O_VLD at cycle 1, DZ=1, Q=0x7FFF, R=0. A=-5, B=0 -> Q=0x8001.
- A=0x4000, B=1 -> OVF=1. With DIVIDER_FX_SAT_EN, Q=0x7FFF; without it, Q=0x0000.
- D_W=16, FRAC_W=0:
  - A=-32768, B=1 -> Q=0x8000, OVF=0.
  - A=-32768, B=-1 -> OVF=1; Q=0x7FFF with SAT, 0x8000 without.
- Hold I_RDY=0 for 5 cycles in S_DONE -> outputs stable, O_RDY=0, I_VLD ignored. Then I_RDY=1 -> O_VLD low next cycle, O_RDY=1.
- Assert I_RST for 1 cycle mid-S_CALC -> all outputs reset next cycle, O_RDY=1. A new operation then completes correctly.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared state encodings and sizing helpers for the fixed-point divider.
package divider_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_CALC = 3'b010,
        S_DONE = 3'b100
    } state_t;

    // One quotient bit per cycle: integer bits plus appended fractional bits.
    function automatic int div_iter(input int d_w, input int frac_w);
        return d_w + frac_w;
    endfunction

    function automatic int cnt_width(input int iter);
        return $clog2(iter + 1);
    endfunction

endpackage

// File: rtl/divider_sgn_mag.sv
// Conditional two's-complement negation: yields |val| when neg is the sign bit,
// and restores a signed value from a magnitude when neg is the result sign.
module divider_sgn_mag #(
    parameter int D_W = 16
) (
    input  logic [D_W-1:0] val,
    input  logic           neg,
    output logic [D_W-1:0] result
);

    assign result = neg ? (~val + D_W'(1)) : val;

endmodule

// File: rtl/divider_fx.sv
// Signed fixed-point restoring divider, Q = (A << FRAC_W) / B, one quotient bit per cycle.
// Define DIVIDER_FX_SAT_EN to clamp the quotient on overflow instead of wrapping.
module divider_fx
    import divider_pkg::*;
#(
    parameter int D_W    = 16,
    parameter int FRAC_W = 8
) (
    input  logic           I_CLK,
    input  logic           I_RST,
    input  logic           I_VLD,
    output logic           O_RDY,
    input  logic [D_W-1:0] I_DIVIDEND,
    input  logic [D_W-1:0] I_DIVISOR,
    output logic           O_VLD,
    input  logic           I_RDY,
    output logic [D_W-1:0] O_QUOTIENT,
    output logic [D_W-1:0] O_REMAINDER,
    output logic           O_DZ,
    output logic           O_OVF
);

    localparam int ITER  = div_iter(D_W, FRAC_W);
    localparam int CNT_W = cnt_width(ITER);

    localparam logic [ITER-1:0] NEG_LIM = ITER'(1) << (D_W - 1);
    localparam logic [ITER-1:0] POS_LIM = NEG_LIM - ITER'(1);
    localparam logic [D_W-1:0]  Q_MAX   = {1'b0, {(D_W-1){1'b1}}};
    localparam logic [D_W-1:0]  Q_MIN   = {1'b1, {(D_W-1){1'b0}}};
    localparam logic [D_W-1:0]  DZ_NEG  = Q_MIN | D_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [ITER-1:0]  num;
    logic [ITER-1:0]  qmag;
    logic [D_W-1:0]   prem;
    logic [D_W-1:0]   b_mag;
    logic             sign_a;
    logic             sign_b;

    logic [D_W-1:0]   a_mag_in;
    logic [D_W-1:0]   b_mag_in;
    logic [D_W:0]     p_trial;
    logic [D_W:0]     p_diff;
    logic             p_ge;
    logic [D_W-1:0]   p_next;
    logic [ITER-1:0]  q_next;
    logic             res_neg;
    logic             ovf;
    logic [D_W-1:0]   q_wrap;
    logic [D_W-1:0]   q_final;
    logic [D_W-1:0]   r_final;

    divider_sgn_mag #(.D_W(D_W)) u_abs_a (
        .val    (I_DIVIDEND),
        .neg    (I_DIVIDEND[D_W-1]),
        .result (a_mag_in)
    );

    divider_sgn_mag #(.D_W(D_W)) u_abs_b (
        .val    (I_DIVISOR),
        .neg    (I_DIVISOR[D_W-1]),
        .result (b_mag_in)
    );

    // The trial value is one bit wider than the remainder; its borrow decides the quotient bit.
    assign p_trial = {prem, num[ITER-1]};
    assign p_diff  = p_trial - {1'b0, b_mag};
    assign p_ge    = ~p_diff[D_W];
    assign p_next  = p_ge ? p_diff[D_W-1:0] : p_trial[D_W-1:0];
    assign q_next  = (qmag << 1) | ITER'(p_ge);

    assign res_neg = sign_a ^ sign_b;
    assign ovf     = res_neg ? (q_next > NEG_LIM) : (q_next > POS_LIM);

    divider_sgn_mag #(.D_W(D_W)) u_neg_q (
        .val    (q_next[D_W-1:0]),
        .neg    (res_neg),
        .result (q_wrap)
    );

    divider_sgn_mag #(.D_W(D_W)) u_neg_r (
        .val    (p_next),
        .neg    (sign_a),
        .result (r_final)
    );

`ifdef DIVIDER_FX_SAT_EN
    assign q_final = ovf ? (res_neg ? Q_MIN : Q_MAX) : q_wrap;
`else
    assign q_final = q_wrap;
`endif

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state       <= S_IDLE;
            O_RDY       <= 1'b1;
            O_VLD       <= 1'b0;
            O_QUOTIENT  <= '0;
            O_REMAINDER <= '0;
            O_DZ        <= 1'b0;
            O_OVF       <= 1'b0;
            cnt         <= '0;
            num         <= '0;
            qmag        <= '0;
            prem        <= '0;
            b_mag       <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (I_VLD && O_RDY) begin
                        sign_a <= I_DIVIDEND[D_W-1];
                        sign_b <= I_DIVISOR[D_W-1];
                        b_mag  <= b_mag_in;
                        num    <= ITER'(a_mag_in) << FRAC_W;
                        qmag   <= '0;
                        prem   <= '0;
                        cnt    <= CNT_W'(ITER - 1);
                        O_RDY  <= 1'b0;
                        if (I_DIVISOR == '0) begin
                            state       <= S_DONE;
                            O_VLD       <= 1'b1;
                            O_DZ        <= 1'b1;
                            O_OVF       <= 1'b0;
                            O_REMAINDER <= '0;
                            O_QUOTIENT  <= I_DIVIDEND[D_W-1] ? DZ_NEG : Q_MAX;
                        end else begin
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    num  <= num << 1;
                    qmag <= q_next;
                    prem <= p_next;
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state       <= S_DONE;
                        O_VLD       <= 1'b1;
                        O_QUOTIENT  <= q_final;
                        O_REMAINDER <= r_final;
                        O_DZ        <= 1'b0;
                        O_OVF       <= ovf;
                    end
                end
                S_DONE: begin
                    if (I_RDY) begin
                        state <= S_IDLE;
                        O_VLD <= 1'b0;
                        O_RDY <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    O_VLD <= 1'b0;
                    O_RDY <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_fx.sv
// Scoreboard bench for divider_fx: a FRAC_W=8 and a FRAC_W=0 instance share stimulus.
// Expectations follow DIVIDER_FX_SAT_EN the same way the design does.
module tb_divider_fx;

    typedef struct {
        logic [15:0] quo;
        logic [15:0] rem;
        logic        dz;
        logic        ovf;
        int          acc_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_vld;
    logic        i_rdy;
    logic [15:0] dividend;
    logic [15:0] divisor;

    logic        rdy_f, vld_f, dz_f, ovf_f;
    logic [15:0] quo_f, rem_f;
    logic        rdy_i, vld_i, dz_i, ovf_i;
    logic [15:0] quo_i, rem_i;

    exp_t sb_frac[$];
    exp_t sb_int[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    bit   seen_f     = 0;
    bit   seen_i     = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    divider_fx #(.D_W(16), .FRAC_W(8)) u_frac (
        .I_CLK(clk), .I_RST(rst), .I_VLD(i_vld), .O_RDY(rdy_f),
        .I_DIVIDEND(dividend), .I_DIVISOR(divisor), .O_VLD(vld_f), .I_RDY(i_rdy),
        .O_QUOTIENT(quo_f), .O_REMAINDER(rem_f), .O_DZ(dz_f), .O_OVF(ovf_f)
    );

    divider_fx #(.D_W(16), .FRAC_W(0)) u_int (
        .I_CLK(clk), .I_RST(rst), .I_VLD(i_vld), .O_RDY(rdy_i),
        .I_DIVIDEND(dividend), .I_DIVISOR(divisor), .O_VLD(vld_i), .I_RDY(i_rdy),
        .O_QUOTIENT(quo_i), .O_REMAINDER(rem_i), .O_DZ(dz_i), .O_OVF(ovf_i)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference built on native signed division, which truncates toward zero
    // and gives the remainder the dividend's sign.
    function automatic exp_t model(input logic signed [15:0] a, input logic signed [15:0] b, input int frac);
        exp_t   e;
        longint n, q, r;
        bit     neg;
        e.acc_cyc = 0;
        if (b == 0) begin
            e.dz  = 1'b1;
            e.ovf = 1'b0;
            e.rem = 16'h0000;
            e.quo = (a < 0) ? 16'h8001 : 16'h7FFF;
            return e;
        end
        n     = longint'(a) * (longint'(1) << frac);
        q     = n / longint'(b);
        r     = n % longint'(b);
        neg   = (a < 0) != (b < 0);
        e.dz  = 1'b0;
        e.ovf = neg ? (-q > 32768) : (q > 32767);
        e.rem = 16'(r);
`ifdef DIVIDER_FX_SAT_EN
        e.quo = e.ovf ? (neg ? 16'h8000 : 16'h7FFF) : 16'(q);
`else
        e.quo = 16'(q);
`endif
        return e;
    endfunction

    task automatic checkResult(input string tag, input logic rdy, input logic [15:0] quo,
                               input logic [15:0] rem, input logic dz, input logic ovf, input exp_t e);
        checkOutput({tag, "_quotient"}, quo, e.quo);
        checkOutput({tag, "_remainder"}, rem, e.rem);
        checkOutput({tag, "_dz"}, dz, e.dz);
        checkOutput({tag, "_ovf"}, ovf, e.ovf);
        checkOutput({tag, "_rdy_busy"}, rdy, 1'b0);
    endtask

    // Result monitors: every valid cycle is checked against the queue head, popped on handshake.
    always @(negedge clk) begin
        if (rst) begin
            seen_f = 0;
        end else if (vld_f) begin
            if (sb_frac.size() == 0) begin
                checkOutput("frac_unexpected_vld", 1, 0);
            end else begin
                if (!seen_f) begin
                    seen_f = 1;
                    checkOutput("frac_latency", cyc - sb_frac[0].acc_cyc + 1, sb_frac[0].dz ? 1 : 25);
                end
                checkResult("frac", rdy_f, quo_f, rem_f, dz_f, ovf_f, sb_frac[0]);
                if (i_rdy) begin
                    void'(sb_frac.pop_front());
                    seen_f = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            seen_i = 0;
        end else if (vld_i) begin
            if (sb_int.size() == 0) begin
                checkOutput("int_unexpected_vld", 1, 0);
            end else begin
                if (!seen_i) begin
                    seen_i = 1;
                    checkOutput("int_latency", cyc - sb_int[0].acc_cyc + 1, sb_int[0].dz ? 1 : 17);
                end
                checkResult("int", rdy_i, quo_i, rem_i, dz_i, ovf_i, sb_int[0]);
                if (i_rdy) begin
                    void'(sb_int.pop_front());
                    seen_i = 0;
                end
            end
        end
    end

    task automatic applyStimulus(input logic signed [15:0] a, input logic signed [15:0] b);
        exp_t e;
        int   waited = 0;
        while (!(rdy_f && rdy_i) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!(rdy_f && rdy_i)) begin
            checkOutput("rdy_timeout", {rdy_f, rdy_i}, 2'b11);
            return;
        end
        dividend = a;
        divisor  = b;
        i_vld    = 1'b1;
        @(posedge clk);
        #1;
        i_vld    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
        e = model(a, b, 8);
        e.acc_cyc = cyc;
        sb_frac.push_back(e);
        e = model(a, b, 0);
        e.acc_cyc = cyc;
        sb_int.push_back(e);
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((sb_frac.size() != 0 || sb_int.size() != 0) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb_frac.size() != 0 || sb_int.size() != 0)
            checkOutput("drain_timeout", sb_frac.size() + sb_int.size(), 0);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_rdy"}, {rdy_f, rdy_i}, 2'b11);
        checkOutput({tag, "_vld"}, {vld_f, vld_i}, 2'b00);
        checkOutput({tag, "_quotient"}, {quo_f, quo_i}, 32'h0);
        checkOutput({tag, "_remainder"}, {rem_f, rem_i}, 32'h0);
        checkOutput({tag, "_flags"}, {dz_f, ovf_f, dz_i, ovf_i}, 4'h0);
    endtask

    shortint vec_a[16] = '{3, 100, -7, -100, 5, -5, 0, 16384, -32768, -32768, 0, 32767, -32768, 7, -1, 255};
    shortint vec_b[16] = '{2, 3, 2, 3, 0, 0, 0, 1, 1, -1, -5, -1, -32768, -32768, 3, -2};

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no completion, expected the bench to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        i_vld    = 1'b0;
        i_rdy    = 1'b1;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        checkIdleOutputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 16; i++)
            applyStimulus(vec_a[i], vec_b[i]);
        for (int i = 0; i < 8; i++)
            applyStimulus(16'($urandom), 16'($urandom_range(0, 65535)));
        waitIdle();

        // Backpressure: result held, new operands offered and ignored, then released.
        i_rdy = 1'b0;
        applyStimulus(1234, -7);
        for (int n = 0; n < 100 && !(vld_f && vld_i); n++)
            @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            i_vld    = 1'b1;
            dividend = 16'($urandom);
            divisor  = 16'($urandom);
        end
        @(posedge clk);
        #1;
        i_vld = 1'b0;
        i_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("bp_vld_low", {vld_f, vld_i}, 2'b00);
        checkOutput("bp_rdy_high", {rdy_f, rdy_i}, 2'b11);
        waitIdle();

        // Reset in the middle of a computation discards it.
        applyStimulus(1000, 7);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_frac.delete();
        sb_int.delete();
        checkIdleOutputs("midreset");
        applyStimulus(1000, 7);
        applyStimulus(-1000, 7);
        waitIdle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
